// File: rtl/i2s_rx_oversampled.sv
// I2S / left-justified receiver: oversamples sck/ws/sd on clk_i, deserializes slots into words, queues them in a FIFO.
// Latency: pin-to-sample 3 clk_i; word visible on data_valid_o 1 clk_i after the sampled edge that completed it.
// Backpressure: data_ready_i pops the FIFO; a word arriving while full with no pop is dropped and sets overflow_o.
module i2s_rx_oversampled #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sck_i,
    input  logic        ws_i,
    input  logic        sd_i,
    input  logic        cfg_en_i,
    input  logic        cfg_i2s_mode_i,
    input  logic        cfg_lsb_first_i,
    input  logic [4:0]  cfg_word_size_i,
    input  logic        clr_err_i,
    output logic [31:0] data_o,
    output logic        data_ch_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        overflow_o,
    output logic        short_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SHIFT,
        ST_SKIP
    } state_e;

    // input synchronizers: bit 2 = sck, bit 1 = ws, bit 0 = sd
    logic [2:0]  in_s1_q, in_s1_d;
    logic [2:0]  in_s2_q, in_s2_d;
    logic        sck_h_q, sck_h_d;

    logic        ws_prev_q, ws_prev_d;
    logic        ws_eff_prev_q, ws_eff_prev_d;
    state_e      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        chan_q, chan_d;
    logic        ovf_q, ovf_d;
    logic        short_q, short_d;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [32:0] mem_q [FIFO_DEPTH];

    logic        sck_rise;
    logic        ws_smp;
    logic        sd_smp;
    logic        ws_eff;
    logic        ws_chg;
    logic [5:0]  word_len;
    logic        push;
    logic        short_set;
    logic [32:0] push_dat;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        wr_en;
    logic        ovf_set;
    logic [32:0] head;

    assign in_s1_d  = {sck_i, ws_i, sd_i};
    assign in_s2_d  = in_s1_q;
    assign sck_h_d  = in_s2_q[2];
    assign sck_rise = in_s2_q[2] & ~sck_h_q;
    assign ws_smp   = in_s2_q[1];
    assign sd_smp   = in_s2_q[0];
    // I2S mode delays WS by one bit so that the slot boundary lines up with its MSB
    assign ws_eff   = cfg_i2s_mode_i ? ws_prev_q : ws_smp;
    assign ws_chg   = ws_eff ^ ws_eff_prev_q;
    assign word_len = {1'b0, cfg_word_size_i} + 6'd1;

    // slot FSM and deserializer; WS history keeps tracking while disabled so SYNC needs a real transition
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        chan_d        = chan_q;
        ws_prev_d     = ws_prev_q;
        ws_eff_prev_d = ws_eff_prev_q;
        push          = 1'b0;
        short_set     = 1'b0;

        if (sck_rise) begin
            ws_prev_d     = ws_smp;
            ws_eff_prev_d = ws_eff;
        end

        case (state_q)
            ST_IDLE: begin
                shreg_d = '0;
                cnt_d   = '0;
                if (cfg_en_i) state_d = ST_SYNC;
            end
            ST_SHIFT: begin
                if (sck_rise && !ws_chg) begin
                    if (cfg_lsb_first_i) shreg_d[cnt_q[4:0]] = sd_smp;
                    else                 shreg_d = {shreg_q[30:0], sd_smp};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_d == word_len) begin
                        push    = 1'b1;
                        state_d = ST_SKIP;
                    end
                end
            end
            default: ;
        endcase

        // a WS change opens a new slot from SYNC, SKIP, or (prematurely) SHIFT
        if (state_q != ST_IDLE && sck_rise && ws_chg) begin
            short_set = (state_q == ST_SHIFT);
            chan_d    = ws_eff;
            shreg_d   = {31'b0, sd_smp};
            cnt_d     = 6'd1;
            if (cfg_word_size_i == 5'd0) begin
                push    = 1'b1;
                state_d = ST_SKIP;
            end else begin
                state_d = ST_SHIFT;
            end
        end

        if (!cfg_en_i) begin
            state_d   = ST_IDLE;
            push      = 1'b0;
            short_set = 1'b0;
        end
    end

    assign push_dat = {chan_d, shreg_d};

    // FIFO pointer and sticky-flag next state
    always_comb begin
        flush      = !cfg_en_i || (state_q == ST_IDLE);
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = ((wptr_q - rptr_q) == FULL_CNT);
        pop        = !fifo_empty && data_ready_i;
        wr_en      = push && (!fifo_full || pop);
        ovf_set    = push && fifo_full && !pop;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PTR_ONE;
            if (pop)   rptr_d = rptr_q + PTR_ONE;
        end
        ovf_d   = ovf_set   | (ovf_q   & ~clr_err_i & cfg_en_i);
        short_d = short_set | (short_q & ~clr_err_i & cfg_en_i);
    end

    // all control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_s1_q       <= '0;
            in_s2_q       <= '0;
            sck_h_q       <= 1'b0;
            ws_prev_q     <= 1'b0;
            ws_eff_prev_q <= 1'b0;
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            chan_q        <= 1'b0;
            ovf_q         <= 1'b0;
            short_q       <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            in_s1_q       <= in_s1_d;
            in_s2_q       <= in_s2_d;
            sck_h_q       <= sck_h_d;
            ws_prev_q     <= ws_prev_d;
            ws_eff_prev_q <= ws_eff_prev_d;
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            chan_q        <= chan_d;
            ovf_q         <= ovf_d;
            short_q       <= short_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    // FIFO storage, written directly on the completing edge so valid follows one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign head         = mem_q[rptr_q[AW-1:0]];
    assign data_valid_o = !fifo_empty;
    assign data_o       = fifo_empty ? 32'd0 : head[31:0];
    assign data_ch_o    = fifo_empty ? 1'b0 : head[32];
    assign overflow_o   = ovf_q;
    assign short_o      = short_q;

endmodule
